// File: rtl/float_result_queue_if.sv
// rtl/float_result_queue_if.sv - valid/ready result stream carrying a float result and its IEEE flags
interface float_result_queue_if;
  logic        valid;
  logic        ready;
  logic [31:0] result;
  logic [4:0]  flags;

  modport master (output valid, output result, output flags, input ready);
  modport slave  (input valid, input result, input flags, output ready);
endinterface

// File: rtl/float_result_queue.sv
// rtl/float_result_queue.sv - show-ahead FIFO for float_alu results with sticky flags and result count
module float_result_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  float_result_queue_if.slave  in_s,
  float_result_queue_if.master out_m,
  input  logic                 sticky_clr,
  output logic [4:0]           sticky_flags,
  output logic [ADDR_W:0]      level,
  output logic [CNT_W-1:0]     result_cnt
);

  localparam logic [ADDR_W:0] LVL_FULL = DEPTH[ADDR_W:0];

  logic [36:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;

  // Occupancy alone decides full/empty; ready never looks at out_ready.
  assign in_s.ready  = (level != LVL_FULL);
  assign out_m.valid = (level != '0);
  assign push        = in_s.valid & in_s.ready;
  assign pop         = out_m.valid & out_m.ready;

  // Storage is cleared on reset so the head reads zero until the first push.
  assign {out_m.result, out_m.flags} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      sticky_flags <= '0;
      result_cnt   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_s.result, in_s.flags};
        wr_ptr      <= wr_ptr + 1'b1;
        result_cnt  <= result_cnt + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // A clear in the same cycle as a push keeps exactly the pushed flags.
      sticky_flags <= (sticky_clr ? 5'b0 : sticky_flags) | (push ? in_s.flags : 5'b0);
    end
  end

endmodule

// File: tb/tb_float_result_queue.sv
// tb/tb_float_result_queue.sv - directed self-checking bench for float_result_queue
module tb_float_result_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        sticky_clr;
  logic [4:0]  sticky_flags;
  logic [2:0]  level;
  logic [15:0] result_cnt;
  int          passed = 0;
  int          total = 0;
  logic [15:0] exp_cnt = '0;

  float_result_queue_if up ();
  float_result_queue_if dn ();

  float_result_queue #(.DEPTH(4), .ADDR_W(2), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_s         (up),
    .out_m        (dn),
    .sticky_clr   (sticky_clr),
    .sticky_flags (sticky_flags),
    .level        (level),
    .result_cnt   (result_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up.valid = 1'b0; up.result = 'x; up.flags = 'x;
    dn.ready = 1'b0; sticky_clr = 1'b0;
    step(); step();
    rst_n = 1'b1;
    exp_cnt = '0;
    total++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else passed++;
    total++; if (dn.valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", dn.valid); else passed++;
    total++; if (up.ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", up.ready); else passed++;
    total++; if (sticky_flags !== 5'b0) $display("FAIL reset_sticky got %b want 0", sticky_flags); else passed++;
    total++; if (result_cnt !== 16'd0) $display("FAIL reset_cnt got %0d want 0", result_cnt); else passed++;
    total++; if (dn.result !== 32'h0) $display("FAIL reset_out_result got %h want 0", dn.result); else passed++;
  endtask

  task automatic test_single();
    dn.ready = 1'b1;
    up.valid = 1'b1; up.result = 32'h4194_0000; up.flags = 5'b0;
    step();
    exp_cnt++;
    up.valid = 1'b0; up.result = 'x; up.flags = 'x;
    total++; if (dn.valid !== 1'b1) $display("FAIL single_valid got %b want 1", dn.valid); else passed++;
    total++; if (dn.result !== 32'h4194_0000) $display("FAIL single_result got %h want 41940000", dn.result); else passed++;
    step();
    total++; if (level !== 3'd0) $display("FAIL single_level got %0d want 0", level); else passed++;
    total++; if (dn.valid !== 1'b0) $display("FAIL single_drained got %b want 0", dn.valid); else passed++;
    total++; if (result_cnt !== 16'd1) $display("FAIL single_cnt got %0d want 1", result_cnt); else passed++;
  endtask

  task automatic test_fill();
    logic [31:0] vals [4];
    vals[0] = 32'h41D2_0000; vals[1] = 32'hBE00_0000;
    vals[2] = 32'hC154_0000; vals[3] = 32'h426D_47AE;
    for (int rep = 0; rep < 3; rep++) begin
      dn.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        up.valid = 1'b1; up.result = vals[i]; up.flags = 5'b0;
        step();
        exp_cnt++;
      end
      total++; if (level !== 3'd4) $display("FAIL fill_level rep%0d got %0d want 4", rep, level); else passed++;
      total++; if (up.ready !== 1'b0) $display("FAIL fill_in_ready rep%0d got %b want 0", rep, up.ready); else passed++;
      up.result = 32'hDEAD_BEEF;
      step();
      up.valid = 1'b0; up.result = 'x; up.flags = 'x;
      total++; if (level !== 3'd4) $display("FAIL fill_ignored_level rep%0d got %0d want 4", rep, level); else passed++;
      total++; if (result_cnt !== exp_cnt) $display("FAIL fill_ignored_cnt rep%0d got %0d want %0d", rep, result_cnt, exp_cnt); else passed++;
      dn.ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        total++; if (dn.result !== vals[i]) $display("FAIL fill_drain rep%0d idx%0d got %h want %h", rep, i, dn.result, vals[i]); else passed++;
        step();
      end
      total++; if (level !== 3'd0) $display("FAIL fill_empty rep%0d got %0d want 0", rep, level); else passed++;
    end
  endtask

  task automatic test_sticky();
    logic [4:0] fl [3];
    fl[0] = 5'b10100; fl[1] = 5'b00001; fl[2] = 5'b00010;
    dn.ready = 1'b0;
    sticky_clr = 1'b1; step(); sticky_clr = 1'b0;
    total++; if (sticky_flags !== 5'b0) $display("FAIL sticky_clear got %b want 0", sticky_flags); else passed++;
    up.valid = 1'b1; up.result = 32'hFF80_0000; up.flags = fl[0]; step(); exp_cnt++;
    up.result = 32'h7FC0_0000; up.flags = fl[1]; step(); exp_cnt++;
    up.valid = 1'b0;
    total++; if (sticky_flags !== 5'b10101) $display("FAIL sticky_accum got %b want 10101", sticky_flags); else passed++;
    up.valid = 1'b1; up.result = 32'h3F80_0000; up.flags = fl[2]; sticky_clr = 1'b1;
    step(); exp_cnt++;
    up.valid = 1'b0; up.result = 'x; up.flags = 'x; sticky_clr = 1'b0;
    total++; if (sticky_flags !== 5'b00010) $display("FAIL sticky_clr_push got %b want 00010", sticky_flags); else passed++;
    dn.ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (dn.flags !== fl[i]) $display("FAIL sticky_head_flags idx%0d got %b want %b", i, dn.flags, fl[i]); else passed++;
      step();
    end
    total++; if (sticky_flags !== 5'b00010) $display("FAIL sticky_after_pop got %b want 00010", sticky_flags); else passed++;
  endtask

  task automatic test_back_to_back();
    dn.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up.valid = 1'b1; up.result = 32'h1000 + i; up.flags = 5'b0;
      step(); exp_cnt++;
    end
    dn.ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      up.result = 32'h1000 + 32'(j + 2);
      total++; if (dn.result !== 32'h1000 + 32'(j)) $display("FAIL b2b_order cyc%0d got %h want %h", j, dn.result, 32'h1000 + 32'(j)); else passed++;
      step(); exp_cnt++;
      total++; if (level !== 3'd2) $display("FAIL b2b_level cyc%0d got %0d want 2", j, level); else passed++;
    end
    up.valid = 1'b0; up.result = 'x;
    for (int j = 10; j < 12; j++) begin
      total++; if (dn.result !== 32'h1000 + 32'(j)) $display("FAIL b2b_tail idx%0d got %h want %h", j, dn.result, 32'h1000 + 32'(j)); else passed++;
      step();
    end
    total++; if (result_cnt !== exp_cnt) $display("FAIL b2b_cnt got %0d want %0d", result_cnt, exp_cnt); else passed++;
  endtask

  task automatic test_reset_mid();
    dn.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      up.valid = 1'b1; up.result = 32'hA000 + i; up.flags = 5'b11111;
      step(); exp_cnt++;
    end
    total++; if (level !== 3'd3) $display("FAIL mid_pre_level got %0d want 3", level); else passed++;
    up.result = 32'hBBBB_0000; rst_n = 1'b0;
    step();
    rst_n = 1'b1; exp_cnt = '0;
    total++; if (level !== 3'd0) $display("FAIL mid_level got %0d want 0", level); else passed++;
    total++; if (dn.valid !== 1'b0) $display("FAIL mid_out_valid got %b want 0", dn.valid); else passed++;
    total++; if (dn.result !== 32'h0) $display("FAIL mid_out_result got %h want 0", dn.result); else passed++;
    total++; if (sticky_flags !== 5'b0) $display("FAIL mid_sticky got %b want 0", sticky_flags); else passed++;
    total++; if (result_cnt !== 16'd0) $display("FAIL mid_cnt got %0d want 0", result_cnt); else passed++;
    up.valid = 1'b0; up.result = 'x; up.flags = 'x; dn.ready = 1'b1;
    step(); step();
    total++; if (dn.valid !== 1'b0) $display("FAIL mid_no_stale got %b want 0", dn.valid); else passed++;
    up.valid = 1'b1; up.result = 32'h4000_0000; up.flags = 5'b01000;
    step();
    up.valid = 1'b0;
    total++; if (dn.result !== 32'h4000_0000) $display("FAIL mid_fresh got %h want 40000000", dn.result); else passed++;
    total++; if (result_cnt !== 16'd1) $display("FAIL mid_fresh_cnt got %0d want 1", result_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_sticky();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
